id_exe_register: RTL and testbench
==================================

# id_exe_register

ID/EXE pipeline register for the five-stage CPU: the consumer of the pause signals raised by the load-use hazard detector. It captures decoded instruction fields from ID, inserts a NOP bubble into EXE when `id_exe_pause` is raised, and holds its contents when the back end stalls. It also accepts branch flushes, including a flush that arrives during a stall, and keeps a saturating bubble counter for performance monitoring. Its `exe_reg_op`/`exe_wb_addr` outputs close the loop back to the hazard detector.

## Interface
Parameters:
- `DATA_W`, 16, width of PC, operand and immediate fields
- `ADDR_W`, 4, register address width (`REG_ADDR_BUS`)
- `REG_OP_W`, 2, register-op code width (`REG_OP_BUS`)
- `ALU_OP_W`, 4, ALU op width
- `MEM_OP_W`, 2, memory op width
- `CNT_W`, 16, bubble counter width

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `id_pc`, `id_reg1_data`, `id_reg2_data`, `id_imm`  in  DATA_W each  decoded fields from ID
- `id_wb_addr`  in  ADDR_W  destination register
- `id_reg_op`, `id_alu_op`, `id_mem_op`  in  REG_OP_W / ALU_OP_W / MEM_OP_W  control fields
- `id_exe_pause`  in  1  load-use hazard; inject a bubble this cycle
- `exe_stall`  in  1  back end cannot accept; hold all contents
- `flush`  in  1  branch taken; kill the instruction entering EXE
- `exe_pc`, `exe_reg1_data`, `exe_reg2_data`, `exe_imm`, `exe_wb_addr`, `exe_reg_op`, `exe_alu_op`, `exe_mem_op`  out  matching widths  registered fields to EXE
- `exe_valid`  out  1  EXE holds a real instruction
- `flush_pending`  out  1  a flush is deferred behind a stall
- `bubble_count`  out  CNT_W  number of bubbles inserted, saturating

## Operation
- NOP encoding:
  - `reg_op = REG_OP_NOP`, `alu_op = ALU_OP_NOP`, `mem_op = MEM_OP_NOP`.
  - `wb_addr` = 0, all data fields 0, `exe_valid` = 0.
- Per-edge action, highest priority first:
  1. `exe_stall` = 1: hold every output. If `flush` = 1, set `flush_pending`.
  2. `flush` = 1 or `flush_pending` = 1: load NOP and clear `flush_pending`. This does not count as a bubble.
  3. `id_exe_pause` = 1: load NOP and increment `bubble_count`.
  4. Otherwise: load all `id_*` fields and set `exe_valid` = 1.
- `bubble_count` saturates at all-ones and never wraps.
- A bubble never clears `flush_pending`; only step 2 does.
- `exe_reg_op`/`exe_wb_addr` of a NOP must never match a hazard. Because `reg_op = REG_OP_NOP`, the detector cannot fire on a bubble.

## Timing
- Reset (`rst` low, asynchronous):
  - All field outputs take the NOP encoding.
  - `exe_valid` = 0, `flush_pending` = 0, `bubble_count` = 0.
  - Release is synchronous to the next `clk` edge.
  - A reset mid-stall discards the held instruction and any pending flush.
- Latency: one cycle from ID inputs to `exe_*`.
- The control inputs are combinational from the current cycle and are sampled at the edge.
- Load-use: the detector asserts `id_exe_pause` together with the PC and IF/ID pauses. On the next edge EXE holds a NOP while the consumer stays in ID. One cycle later the consumer enters EXE with forwarded data available.
- `exe_stall` and `id_exe_pause` together: stall wins, and no bubble is counted.
- Simultaneous `flush` and `id_exe_pause` without stall: flush wins, and no bubble is counted.
- `flush` on the cycle `exe_stall` deasserts: applied immediately, equivalent to a pending flush.

## Structure
- Shared `define.v` entries:
  - `REG_OP_*`, `ALU_OP_NOP`, `MEM_OP_NOP` encodings
  - bus widths
  - `PAUSE_ENABLE`/`PAUSE_DISABLE`
  - a new `EXE_STALL_ENABLE`
- Use one sub-module, `sat_counter`, a parameterised saturating counter with enable, for `bubble_count`.
- Everything else is a flat register bank with a priority mux.

## Test plan
- Reset then normal flow: feed `id_pc` = 0x0010, `id_wb_addr` = 3, no control inputs. One cycle later `exe_pc` = 0x0010, `exe_wb_addr` = 3, `exe_valid` = 1.
- Load-use: `id_exe_pause` high for one cycle. Next cycle shows NOP with `exe_valid` = 0 and `bubble_count` = 1. The following cycle the consumer appears with its original fields.
- Stall + flush: `exe_stall` high for 3 cycles with `flush` pulsed in cycle 2. Outputs stay constant and `flush_pending` = 1. On the first unstalled edge EXE shows NOP and `flush_pending` = 0.
- Priority: `flush` and `id_exe_pause` both high gives NOP with `bubble_count` unchanged. `exe_stall` and `id_exe_pause` both high holds outputs with `bubble_count` unchanged.
- Saturation: with `CNT_W` = 4, apply 20 consecutive pauses. `bubble_count` stops at 15.
- Async reset mid-stall: pull `rst` low between edges while a valid instruction is held and a flush is pending. Outputs go to NOP immediately, and `flush_pending` = 0 and `bubble_count` = 0 without a clock edge.

Source files
------------

// File: rtl/id_exe_register_pkg.sv
// Shared encodings and default bus widths for the ID/EXE pipeline register.
package id_exe_register_pkg;

  // Default bus widths
  localparam int DATA_BUS_W   = 16;
  localparam int REG_ADDR_BUS = 4;
  localparam int REG_OP_BUS   = 2;
  localparam int ALU_OP_BUS   = 4;
  localparam int MEM_OP_BUS   = 2;
  localparam int BUBBLE_CNT_W = 16;

  // Register-op encodings; NOP must never look like a register write
  localparam logic [REG_OP_BUS-1:0] REG_OP_NOP   = 2'b00;
  localparam logic [REG_OP_BUS-1:0] REG_OP_READ  = 2'b01;
  localparam logic [REG_OP_BUS-1:0] REG_OP_WRITE = 2'b10;
  localparam logic [REG_OP_BUS-1:0] REG_OP_RW    = 2'b11;

  localparam logic [ALU_OP_BUS-1:0] ALU_OP_NOP = 4'h0;
  localparam logic [MEM_OP_BUS-1:0] MEM_OP_NOP = 2'b00;

  // Control-signal polarities
  localparam logic PAUSE_ENABLE      = 1'b1;
  localparam logic PAUSE_DISABLE     = 1'b0;
  localparam logic EXE_STALL_ENABLE  = 1'b1;
  localparam logic EXE_STALL_DISABLE = 1'b0;

endpackage

// File: rtl/id_exe_register_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Increment when enabled unless already saturated
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_count <= '0;
    else if (i_en && (r_count != {W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/id_exe_register.sv
// ID/EXE pipeline register: captures decoded fields, injects load-use
// bubbles, holds on back-end stall and defers flushes that hit a stall.
module id_exe_register
  import id_exe_register_pkg::*;
#(
  parameter int DATA_W   = DATA_BUS_W,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int REG_OP_W = REG_OP_BUS,
  parameter int ALU_OP_W = ALU_OP_BUS,
  parameter int MEM_OP_W = MEM_OP_BUS,
  parameter int CNT_W    = BUBBLE_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DATA_W-1:0]   i_id_pc,
  input  logic [DATA_W-1:0]   i_id_reg1_data,
  input  logic [DATA_W-1:0]   i_id_reg2_data,
  input  logic [DATA_W-1:0]   i_id_imm,
  input  logic [ADDR_W-1:0]   i_id_wb_addr,
  input  logic [REG_OP_W-1:0] i_id_reg_op,
  input  logic [ALU_OP_W-1:0] i_id_alu_op,
  input  logic [MEM_OP_W-1:0] i_id_mem_op,
  input  logic                i_id_exe_pause,
  input  logic                i_exe_stall,
  input  logic                i_flush,
  output logic [DATA_W-1:0]   o_exe_pc,
  output logic [DATA_W-1:0]   o_exe_reg1_data,
  output logic [DATA_W-1:0]   o_exe_reg2_data,
  output logic [DATA_W-1:0]   o_exe_imm,
  output logic [ADDR_W-1:0]   o_exe_wb_addr,
  output logic [REG_OP_W-1:0] o_exe_reg_op,
  output logic [ALU_OP_W-1:0] o_exe_alu_op,
  output logic [MEM_OP_W-1:0] o_exe_mem_op,
  output logic                o_exe_valid,
  output logic                o_flush_pending,
  output logic [CNT_W-1:0]    o_bubble_count
);

  logic [DATA_W-1:0]   r_pc, r_reg1_data, r_reg2_data, r_imm;
  logic [ADDR_W-1:0]   r_wb_addr;
  logic [REG_OP_W-1:0] r_reg_op;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [MEM_OP_W-1:0] r_mem_op;
  logic                r_valid;
  logic                r_flush_pending;

  logic w_stall, w_kill, w_bubble;

  assign w_stall  = (i_exe_stall == EXE_STALL_ENABLE);
  assign w_kill   = i_flush || r_flush_pending;
  // Only a genuine load-use bubble counts; stall and flush both override it
  assign w_bubble = !w_stall && !w_kill && (i_id_exe_pause == PAUSE_ENABLE);

  // Priority mux: stall holds, flush/pending flush kills, pause bubbles, else load
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc            <= '0;
      r_reg1_data     <= '0;
      r_reg2_data     <= '0;
      r_imm           <= '0;
      r_wb_addr       <= '0;
      r_reg_op        <= REG_OP_W'(REG_OP_NOP);
      r_alu_op        <= ALU_OP_W'(ALU_OP_NOP);
      r_mem_op        <= MEM_OP_W'(MEM_OP_NOP);
      r_valid         <= 1'b0;
      r_flush_pending <= 1'b0;
    end else if (w_stall) begin
      if (i_flush)
        r_flush_pending <= 1'b1;
    end else if (w_kill || w_bubble) begin
      r_pc            <= '0;
      r_reg1_data     <= '0;
      r_reg2_data     <= '0;
      r_imm           <= '0;
      r_wb_addr       <= '0;
      r_reg_op        <= REG_OP_W'(REG_OP_NOP);
      r_alu_op        <= ALU_OP_W'(ALU_OP_NOP);
      r_mem_op        <= MEM_OP_W'(MEM_OP_NOP);
      r_valid         <= 1'b0;
      // A bubble leaves a pending flush alone; only a kill retires it
      if (w_kill)
        r_flush_pending <= 1'b0;
    end else begin
      r_pc            <= i_id_pc;
      r_reg1_data     <= i_id_reg1_data;
      r_reg2_data     <= i_id_reg2_data;
      r_imm           <= i_id_imm;
      r_wb_addr       <= i_id_wb_addr;
      r_reg_op        <= i_id_reg_op;
      r_alu_op        <= i_id_alu_op;
      r_mem_op        <= i_id_mem_op;
      r_valid         <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_bubble),
    .o_count (o_bubble_count)
  );

  assign o_exe_pc        = r_pc;
  assign o_exe_reg1_data = r_reg1_data;
  assign o_exe_reg2_data = r_reg2_data;
  assign o_exe_imm       = r_imm;
  assign o_exe_wb_addr   = r_wb_addr;
  assign o_exe_reg_op    = r_reg_op;
  assign o_exe_alu_op    = r_alu_op;
  assign o_exe_mem_op    = r_mem_op;
  assign o_exe_valid     = r_valid;
  assign o_flush_pending = r_flush_pending;

endmodule

// File: tb/tb_id_exe_register.sv
// Randomised + directed bench for id_exe_register against a behavioural model.
module tb_id_exe_register;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk, rst_n;
  logic [15:0] id_pc, id_r1, id_r2, id_imm;
  logic [3:0]  id_wb;
  logic [1:0]  id_reg_op, id_mem_op;
  logic [3:0]  id_alu_op;
  logic        pause, stall, flush;

  logic [15:0] exe_pc, exe_r1, exe_r2, exe_imm;
  logic [3:0]  exe_wb;
  logic [1:0]  exe_reg_op, exe_mem_op;
  logic [3:0]  exe_alu_op;
  logic        exe_valid, flush_pending;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int errors = 0;

  id_exe_register #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_id_pc(id_pc), .i_id_reg1_data(id_r1), .i_id_reg2_data(id_r2), .i_id_imm(id_imm),
    .i_id_wb_addr(id_wb), .i_id_reg_op(id_reg_op), .i_id_alu_op(id_alu_op), .i_id_mem_op(id_mem_op),
    .i_id_exe_pause(pause), .i_exe_stall(stall), .i_flush(flush),
    .o_exe_pc(exe_pc), .o_exe_reg1_data(exe_r1), .o_exe_reg2_data(exe_r2), .o_exe_imm(exe_imm),
    .o_exe_wb_addr(exe_wb), .o_exe_reg_op(exe_reg_op), .o_exe_alu_op(exe_alu_op), .o_exe_mem_op(exe_mem_op),
    .o_exe_valid(exe_valid), .o_flush_pending(flush_pending), .o_bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: EXE content is either the captured ID bundle or zeros (NOP)
  logic [75:0] m_fields;   // {pc,r1,r2,imm,wb,reg_op,alu_op,mem_op}
  logic        m_valid, m_fp;
  int          m_bc;

  wire [75:0] id_bundle  = {id_pc, id_r1, id_r2, id_imm, id_wb, id_reg_op, id_alu_op, id_mem_op};
  wire [75:0] exe_bundle = {exe_pc, exe_r1, exe_r2, exe_imm, exe_wb, exe_reg_op, exe_alu_op, exe_mem_op};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fields <= '0; m_valid <= 1'b0; m_fp <= 1'b0; m_bc <= 0;
    end else if (stall) begin
      m_fp <= m_fp | flush;
    end else if (flush || m_fp) begin
      m_fields <= '0; m_valid <= 1'b0; m_fp <= 1'b0;
    end else if (pause) begin
      m_fields <= '0; m_valid <= 1'b0;
      m_bc <= (m_bc >= CNT_MAX) ? CNT_MAX : m_bc + 1;
    end else begin
      m_fields <= id_bundle; m_valid <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fields", exe_bundle, m_fields);
      chk("valid_fp", {74'd0, exe_valid, flush_pending}, {74'd0, m_valid, m_fp});
      chk("bubble_count", 76'(bubble_count), 76'(m_bc));
    end
  end

  task automatic set_id(input logic [15:0] pc, input logic [3:0] wb);
    id_pc = pc; id_wb = wb;
    id_r1 = pc ^ 16'h5a5a; id_r2 = pc + 16'h0101; id_imm = ~pc;
    id_reg_op = 2'b10; id_alu_op = 4'h3; id_mem_op = 2'b01;
  endtask

  task automatic cyc(input logic p, input logic s, input logic f);
    pause = p; stall = s; flush = f;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pause = 0; stall = 0; flush = 0;
    set_id(16'h0000, 4'd0);
    #12;
    chk("reset_fields", exe_bundle, '0);
    chk("reset_state", {71'd0, exe_valid, flush_pending, bubble_count}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Normal flow
    set_id(16'h0010, 4'd3);
    cyc(0, 0, 0);
    chk("normal_pc", 76'(exe_pc), 76'h0010);
    chk("normal_wb_valid", {71'd0, exe_wb, exe_valid}, {71'd0, 4'd3, 1'b1});

    // Load-use bubble, then consumer enters
    set_id(16'h0014, 4'd5);
    cyc(1, 0, 0);
    chk("bubble_nop", {exe_bundle[75:60], 60'd0}, '0);
    chk("bubble_valid_cnt", {71'd0, exe_valid, exe_reg_op, bubble_count}, {71'd0, 1'b0, 2'b00, 4'd1});
    cyc(0, 0, 0);
    chk("consumer_pc", {60'd0, exe_pc}, {60'd0, 16'h0014});
    chk("consumer_valid", 76'(exe_valid), 76'd1);

    // Stall with flush in the middle cycle
    set_id(16'h0018, 4'd6);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    chk("stall_hold", {60'd0, exe_pc}, {60'd0, 16'h0014});
    chk("stall_fp", {74'd0, flush_pending, exe_valid}, {74'd0, 1'b1, 1'b1});
    cyc(0, 0, 0);
    chk("pending_kill", {74'd0, flush_pending, exe_valid}, '0);

    // Priority: flush beats pause, stall beats pause
    cyc(1, 0, 1);
    chk("flush_pause", {71'd0, exe_valid, bubble_count}, {71'd0, 1'b0, 4'd1});
    set_id(16'h0020, 4'd7);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("stall_pause", {55'd0, exe_pc, exe_valid, bubble_count}, {55'd0, 16'h0020, 1'b1, 4'd1});

    // Saturation
    repeat (20) cyc(1, 0, 0);
    chk("saturate", 76'(bubble_count), 76'd15);

    // Random traffic
    repeat (600) begin
      set_id(16'($urandom), 4'($urandom));
      id_reg_op = 2'($urandom); id_alu_op = 4'($urandom); id_mem_op = 2'($urandom);
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
    end

    // Async reset mid-stall with a pending flush
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    set_id(16'h0030, 4'd9);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    chk("pre_reset_hold", {58'd0, exe_pc, exe_valid, flush_pending}, {58'd0, 16'h0030, 1'b1, 1'b1});
    pause = 0; stall = 1; flush = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_fields", exe_bundle, '0);
    chk("async_state", {71'd0, exe_valid, flush_pending, bubble_count}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    stall = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
